// File: rtl/pipe_pkg.sv
// Shared types and constants for the decode/execute pipeline boundary.
package pipe_pkg;

  localparam int XLEN      = 32;
  localparam int ALUCTRL_W = 3;
  localparam int RESSRC_W  = 2;

  // ResultSrc encodings
  localparam logic [RESSRC_W-1:0] RES_ALU = 2'd0;
  localparam logic [RESSRC_W-1:0] RES_MEM = 2'd1;
  localparam logic [RESSRC_W-1:0] RES_PC4 = 2'd2;

  // Decoded control word carried from D to E
  typedef struct packed {
    logic                 reg_write;
    logic [RESSRC_W-1:0]  result_src;
    logic                 mem_write;
    logic                 jump;
    logic                 branch;
    logic [ALUCTRL_W-1:0] alu_control;
    logic                 alu_src;
  } ctrl_t;

  // A bubble carries no architectural side effects
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/wb_bypass.sv
// Write-back to decode forwarding for one source operand. The register file
// writes on the edge but reads combinationally, so a W-stage write in the
// same cycle must be forwarded here. x0 is never forwarded.
module wb_bypass
  import pipe_pkg::*;
(
  input  logic [4:0]      Rs,
  input  logic [XLEN-1:0] RD,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic [XLEN-1:0] Op
);

  // Select the W-stage result when it targets this non-zero source register
  always_comb begin
    Op = RD;
    if (RegWriteW && (RdW != 5'd0) && (RdW == Rs)) begin
      Op = ResultW;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with W->D bypass on both operands,
// hazard-unit driven stall/flush, and a count of inserted bubbles.
module id_ex_stage
  import pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic                 ValidD,
  input  logic [XLEN-1:0]      RD1D,
  input  logic [XLEN-1:0]      RD2D,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           RdD,
  input  logic [XLEN-1:0]      PCD,
  input  logic [XLEN-1:0]      PCPlus4D,
  input  logic [XLEN-1:0]      ImmExtD,
  input  logic                 RegWriteD,
  input  logic                 MemWriteD,
  input  logic                 JumpD,
  input  logic                 BranchD,
  input  logic                 ALUSrcD,
  input  logic [RESSRC_W-1:0]  ResultSrcD,
  input  logic [ALUCTRL_W-1:0] ALUControlD,
  input  logic                 RegWriteW,
  input  logic [4:0]           RdW,
  input  logic [XLEN-1:0]      ResultW,
  output logic [XLEN-1:0]      RD1E,
  output logic [XLEN-1:0]      RD2E,
  output logic [XLEN-1:0]      PCE,
  output logic [XLEN-1:0]      PCPlus4E,
  output logic [XLEN-1:0]      ImmExtE,
  output logic [4:0]           Rs1E,
  output logic [4:0]           Rs2E,
  output logic [4:0]           RdE,
  output logic                 RegWriteE,
  output logic                 MemWriteE,
  output logic                 JumpE,
  output logic                 BranchE,
  output logic                 ALUSrcE,
  output logic [RESSRC_W-1:0]  ResultSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 ValidE,
  output logic [31:0]          BubbleCntE
);

  logic [4:0]      rs_d [2];
  logic [XLEN-1:0] rf_d [2];
  logic [XLEN-1:0] op_d [2];

  assign rs_d[0] = Rs1D;
  assign rs_d[1] = Rs2D;
  assign rf_d[0] = RD1D;
  assign rf_d[1] = RD2D;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_byp
      wb_bypass u_byp (
        .Rs        (rs_d[gi]),
        .RD        (rf_d[gi]),
        .RegWriteW (RegWriteW),
        .RdW       (RdW),
        .ResultW   (ResultW),
        .Op        (op_d[gi])
      );
    end
  endgenerate

  ctrl_t ctrl_d;
  logic  bubble_d;
  logic  load_d;

  // Pack decoded control and resolve flush > stall > load priority
  always_comb begin
    ctrl_d             = CTRL_BUBBLE;
    ctrl_d.reg_write   = RegWriteD;
    ctrl_d.result_src  = ResultSrcD;
    ctrl_d.mem_write   = MemWriteD;
    ctrl_d.jump        = JumpD;
    ctrl_d.branch      = BranchD;
    ctrl_d.alu_control = ALUControlD;
    ctrl_d.alu_src     = ALUSrcD;
    // An invalid D slot that is allowed to advance becomes a bubble too
    bubble_d = FlushE || (!StallE && !ValidD);
    load_d   = !FlushE && !StallE && ValidD;
  end

  ctrl_t           ctrl_reg;
  logic [XLEN-1:0] rd1_reg, rd2_reg, pc_reg, pc4_reg, imm_reg;
  logic [4:0]      rs1_reg, rs2_reg, rdst_reg;
  logic            valid_reg;
  logic [31:0]     bubble_cnt_reg;

  // E-stage register: clear on reset or bubble, hold on stall, else capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_reg       <= CTRL_BUBBLE;
      rd1_reg        <= '0;
      rd2_reg        <= '0;
      pc_reg         <= '0;
      pc4_reg        <= '0;
      imm_reg        <= '0;
      rs1_reg        <= '0;
      rs2_reg        <= '0;
      rdst_reg       <= '0;
      valid_reg      <= 1'b0;
      bubble_cnt_reg <= '0;
    end else if (bubble_d) begin
      ctrl_reg       <= CTRL_BUBBLE;
      rd1_reg        <= '0;
      rd2_reg        <= '0;
      pc_reg         <= '0;
      pc4_reg        <= '0;
      imm_reg        <= '0;
      rs1_reg        <= '0;
      rs2_reg        <= '0;
      rdst_reg       <= '0;
      valid_reg      <= 1'b0;
      bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
    end else if (load_d) begin
      ctrl_reg       <= ctrl_d;
      rd1_reg        <= op_d[0];
      rd2_reg        <= op_d[1];
      pc_reg         <= PCD;
      pc4_reg        <= PCPlus4D;
      imm_reg        <= ImmExtD;
      rs1_reg        <= Rs1D;
      rs2_reg        <= Rs2D;
      rdst_reg       <= RdD;
      valid_reg      <= 1'b1;
    end
  end

  assign RD1E        = rd1_reg;
  assign RD2E        = rd2_reg;
  assign PCE         = pc_reg;
  assign PCPlus4E    = pc4_reg;
  assign ImmExtE     = imm_reg;
  assign Rs1E        = rs1_reg;
  assign Rs2E        = rs2_reg;
  assign RdE         = rdst_reg;
  assign RegWriteE   = ctrl_reg.reg_write;
  assign MemWriteE   = ctrl_reg.mem_write;
  assign JumpE       = ctrl_reg.jump;
  assign BranchE     = ctrl_reg.branch;
  assign ALUSrcE     = ctrl_reg.alu_src;
  assign ResultSrcE  = ctrl_reg.result_src;
  assign ALUControlE = ctrl_reg.alu_control;
  assign ValidE      = valid_reg;
  assign BubbleCntE  = bubble_cnt_reg;

endmodule
